regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//   Parametrised multi-port integer register file for the pipelined core. Replaces
//   the single-write, dual-read file. Adds: N read / M write ports, write-to-read
//   bypass, hardwired x0, and a per-register pending scoreboard for decode stalls.
//   Sits between decode (reads, issue) and writeback (writes).
// PARAMETERS
//   DATA_WIDTH     32  bits per register
//   ADDRESS_WIDTH  5   register address bits
//   NUM_REGS       32  number of registers, <= 2**ADDRESS_WIDTH
//   NUM_RD         2   read ports
//   NUM_WR         2   write ports
//   ZERO_REG       1   1: reg 0 reads 0, ignores writes, never pending
//   BYPASS         1   1: same-cycle write data is forwarded to matching reads
// PORTS
//   clk         in   1                      clock, all state updates on posedge
//   rst         in   1                      async active-high reset
//   wr_en       in   NUM_WR                 per-port write enable
//   wr_addr     in   NUM_WR*ADDRESS_WIDTH   write addresses, port k at [k*AW +: AW]
//   wr_data     in   NUM_WR*DATA_WIDTH      write data, port k at [k*DW +: DW]
//   rd_addr     in   NUM_RD*ADDRESS_WIDTH   read addresses
//   rd_data     out  NUM_RD*DATA_WIDTH      read data, combinational
//   rd_pending  out  NUM_RD                 1: read value is stale (write outstanding)
//   iss_en      in   1                      decode requests to reserve iss_addr
//   iss_addr    in   ADDRESS_WIDTH          destination register being issued
//   iss_ok      out  1                      1: reservation accepted this cycle
// BEHAVIOUR
//   Reset: clk is the only clock; rst is asynchronous, active-high. While rst=1,
//     all registers = 0 and all pending bits = 0 immediately, with no clock edge.
//     Outputs under reset: rd_data = 0, rd_pending = 0, iss_ok = 1. Reset mid-write
//     discards the write. First update is the first posedge after rst falls.
//   Write: on posedge, for each port k with wr_en[k], reg[wr_addr_k] <= wr_data_k.
//     Same address on several ports in one cycle: highest port index wins.
//     wr_addr >= NUM_REGS is ignored.
//     ZERO_REG=1: writes to reg 0 are dropped.
//   Read: zero-latency combinational. rd_data_j = reg[rd_addr_j].
//     rd_addr >= NUM_REGS reads 0.
//     BYPASS=1: if any enabled write port targets rd_addr_j this cycle,
//     rd_data_j = that wr_data (highest index wins). BYPASS=0: old value until the
//     edge. ZERO_REG=1: reg 0 always reads 0, bypass included.
//   Scoreboard: pending[NUM_REGS] bits, one per register, reset to 0.
//     hit_clr(a) = any enabled write to a this cycle.
//     iss_ok = !iss_en | !pending[iss_addr] | hit_clr(iss_addr).
//       This stalls WAW, so there is at most one outstanding write per register.
//     Posedge update, per register a:
//       set if iss_en & iss_ok & iss_addr==a.
//       else clear if hit_clr(a).
//       Set wins over a same-cycle clear of the same register.
//     Write to a non-pending register: allowed; data written, pending unchanged.
//     ZERO_REG=1: iss to reg 0 is always ok and never recorded.
//     iss_addr >= NUM_REGS: iss_ok = 1, nothing recorded.
//   rd_pending_j = pending[rd_addr_j] & !(BYPASS & hit_clr(rd_addr_j)).
//   No handshake beyond iss_en/iss_ok; writes are always accepted.
// TESTING
//   1) rst=1 mid-run, no clock edge -> all rd_data=0, rd_pending=0, iss_ok=1.
//      Then write x5=0xDEADBEEF -> next cycle reads 0xDEADBEEF.
//   2) Ports 0 and 1 write x7=0x11 and x7=0x22 in the same cycle -> x7=0x22.
//      Same cycle, BYPASS=1: rd_addr=7 returns 0x22.
//   3) Write x0=0xFFFF_FFFF; issue x0 twice -> rd x0=0, iss_ok=1 both times,
//      rd_pending=0.
//   4) Issue x3 -> pending. Issue x3 again -> iss_ok=0 (stall).
//      Write x3=0x55 -> same cycle: rd_data=0x55, rd_pending=0. Next cycle:
//      pending[3]=0.
//   5) x9 pending; same cycle: write x9=0xA5 and issue x9 -> iss_ok=1; after the
//      edge pending[9]=1 and reg=0xA5.
//   6) BYPASS=0, NUM_RD=4, NUM_WR=1: write x2=0x1234 -> same-cycle read returns
//      the old value; the next cycle reads 0x1234 on all four ports.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass, hardwired x0,
// and a per-register pending scoreboard used by decode to stall on outstanding writes.
module regfile_mp_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_WR-1:0]               i_wr_en,
    input  logic [NUM_WR*ADDRESS_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]    i_wr_data,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    o_rd_data,
    output logic [NUM_RD-1:0]               o_rd_pending,
    input  logic                            i_iss_en,
    input  logic [ADDRESS_WIDTH-1:0]        i_iss_addr,
    output logic                            o_iss_ok
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_WIDTH;

    logic [DW-1:0]       r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;

    logic [NUM_REGS-1:0] w_hit;
    logic [DW-1:0]       w_wdata [NUM_REGS];
    logic [NUM_REGS-1:0] w_iss_sel;
    logic                w_iss_ok;

    // Per-register write decode; ascending port scan lets the highest port win.
    // Reg 0 is never hit when hardwired, so it can never be written or cleared.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_hit[r]   = 1'b0;
            w_wdata[r] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == AW'(r)) &&
                    !(ZERO_REG != 0 && r == 0)) begin
                    w_hit[r]   = 1'b1;
                    w_wdata[r] = i_wr_data[k*DW +: DW];
                end
            end
        end
    end

    // Out-of-range and hardwired-zero issue addresses select nothing, so they
    // are always accepted and never recorded.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_iss_sel[r] = i_iss_en && (i_iss_addr == AW'(r)) &&
                           !(ZERO_REG != 0 && r == 0);
        end
    end

    assign w_iss_ok = i_rst || !(|(w_iss_sel & r_pending & ~w_hit));
    assign o_iss_ok = w_iss_ok;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_hit[r]) begin
                    r_regs[r] <= w_wdata[r];
                end
                // A new reservation outranks the completion of the previous one.
                if (w_iss_sel[r] && w_iss_ok) begin
                    r_pending[r] <= 1'b1;
                end else if (w_hit[r]) begin
                    r_pending[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_rd_data    = '0;
        o_rd_pending = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!i_rst && (i_rd_addr[j*AW +: AW] == AW'(r))) begin
                    if (BYPASS != 0 && w_hit[r]) begin
                        o_rd_data[j*DW +: DW] = w_wdata[r];
                    end else begin
                        o_rd_data[j*DW +: DW] = r_regs[r];
                    end
                    o_rd_pending[j] = r_pending[r] && !(BYPASS != 0 && w_hit[r]);
                end
            end
        end
    end
endmodule
